// File: rtl/controle_empilement_pkg.sv
// Shared definitions for the brick stacking game: FSM states, default
// row geometry and the saturation value of the level counter.
package controle_empilement_pkg;

    // Row controller states
    typedef enum logic [1:0] {
        JEU   = 2'd0,
        PAUSE = 2'd1,
        PERDU = 2'd2
    } etat_e;

    localparam int NB_LED_DEF       = 8;
    localparam int LARGEUR_INIT_DEF = 3;
    localparam int NIVEAU_MAX       = 15;

endpackage

// File: rtl/controle_empilement_compte_bits.sv
// Combinational population count of an NB-bit vector; gives the width of
// the brick left after intersecting it with the row below.
module compte_bits #(
    parameter int NB = 8,
    parameter int WC = $clog2(NB + 1)
) (
    input  logic [NB-1:0] vecteur,
    output logic [WC-1:0] nb_uns
);

    // Sum every bit of the vector
    always_comb begin
        nb_uns = '0;
        for (int i = 0; i < NB; i++) begin
            nb_uns = nb_uns + WC'(vecteur[i]);
        end
    end

endmodule

// File: rtl/controle_empilement.sv
// Row controller for the stacking game: bounces the current brick across
// the row, captures it on a press, intersects it with the stack top and
// reports placements (aligne pulse) or the lost game (perdu level).
module controle_empilement
    import controle_empilement_pkg::*;
#(
    parameter int NB_LED       = NB_LED_DEF,
    parameter int LARGEUR_INIT = LARGEUR_INIT_DEF,
    parameter int PAUSE_TICKS  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              bouton,
    output logic [NB_LED-1:0] leds,
    output logic [NB_LED-1:0] pile,
    output logic              aligne,
    output logic              perdu,
    output logic [3:0]        niveau
);

    localparam int PW = $clog2(NB_LED);
    localparam int WW = $clog2(NB_LED + 1);
    localparam int CW = $clog2(PAUSE_TICKS + 1);

    etat_e              etat_q, etat_d;
    logic [PW-1:0]      pos_q, pos_d;
    logic [WW-1:0]      w_q, w_d;
    logic               dir_q, dir_d;
    logic [NB_LED-1:0]  pile_q, pile_d;
    logic               aligne_q, aligne_d;
    logic               perdu_q, perdu_d;
    logic [3:0]         niveau_q, niveau_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic [NB_LED-1:0]  inter;
    logic [WW-1:0]      w_inter;

    // Brick decode: LED gi is lit when it falls inside [pos, pos+w)
    for (genvar gi = 0; gi < NB_LED; gi++) begin : g_leds
        assign leds[gi] = (gi >= int'(pos_q)) && (gi < int'(pos_q) + int'(w_q));
    end

    assign inter = leds & pile_q;

    compte_bits #(
        .NB (NB_LED),
        .WC (WW)
    ) u_compte_bits (
        .vecteur (inter),
        .nb_uns  (w_inter)
    );

    // Next-state logic: movement, capture/intersection and pause counting
    always_comb begin
        etat_d   = etat_q;
        pos_d    = pos_q;
        w_d      = w_q;
        dir_d    = dir_q;
        pile_d   = pile_q;
        aligne_d = 1'b0;
        perdu_d  = perdu_q;
        niveau_d = niveau_q;
        cnt_d    = cnt_q;
        case (etat_q)
            JEU: begin
                if (bouton) begin
                    // The press wins over a same-cycle tick: compare uses the pre-move brick
                    if (inter != '0) begin
                        pile_d   = inter;
                        w_d      = w_inter;
                        pos_d    = '0;
                        dir_d    = 1'b0;
                        niveau_d = (niveau_q == 4'(NIVEAU_MAX)) ? niveau_q : niveau_q + 4'd1;
                        aligne_d = 1'b1;
                        cnt_d    = '0;
                        etat_d   = PAUSE;
                    end else begin
                        perdu_d = 1'b1;
                        etat_d  = PERDU;
                    end
                end else if (enable && (int'(w_q) < NB_LED)) begin
                    // A full-width brick has nowhere to go and stays put
                    if (!dir_q) begin
                        if (int'(pos_q) + int'(w_q) < NB_LED) begin
                            pos_d = pos_q + PW'(1);
                        end else begin
                            dir_d = 1'b1;
                            pos_d = pos_q - PW'(1);
                        end
                    end else begin
                        if (pos_q != '0) begin
                            pos_d = pos_q - PW'(1);
                        end else begin
                            dir_d = 1'b0;
                            pos_d = pos_q + PW'(1);
                        end
                    end
                end
            end
            PAUSE: begin
                // Presses are ignored; the brick is held for PAUSE_TICKS ticks
                if (enable) begin
                    cnt_d = cnt_q + CW'(1);
                    if (int'(cnt_q) + 1 >= PAUSE_TICKS) begin
                        etat_d = JEU;
                    end
                end
            end
            PERDU: begin
                // Terminal until reset
            end
            default: begin
                etat_d = JEU;
            end
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            etat_q   <= JEU;
            pos_q    <= '0;
            w_q      <= WW'(LARGEUR_INIT);
            dir_q    <= 1'b0;
            pile_q   <= '1;
            aligne_q <= 1'b0;
            perdu_q  <= 1'b0;
            niveau_q <= 4'd0;
            cnt_q    <= '0;
        end else begin
            etat_q   <= etat_d;
            pos_q    <= pos_d;
            w_q      <= w_d;
            dir_q    <= dir_d;
            pile_q   <= pile_d;
            aligne_q <= aligne_d;
            perdu_q  <= perdu_d;
            niveau_q <= niveau_d;
            cnt_q    <= cnt_d;
        end
    end

    assign pile   = pile_q;
    assign aligne = aligne_q;
    assign perdu  = perdu_q;
    assign niveau = niveau_q;

endmodule

// File: tb/tb_controle_empilement.sv
// Self-checking bench for controle_empilement: directed scenarios with
// constant expectations plus a randomized run against a behavioural model.
module tb_controle_empilement;

    localparam int NB = 8;
    localparam int LI = 3;
    localparam int PT = 2;

    localparam int S_PLAY  = 0;
    localparam int S_PAUSE = 1;
    localparam int S_LOST  = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          bouton = 1'b0;
    logic [NB-1:0] leds;
    logic [NB-1:0] pile;
    logic          aligne;
    logic          perdu;
    logic [3:0]    niveau;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    int m_state, m_pos, m_w, m_dir, m_pile, m_aligne, m_perdu, m_niveau, m_cnt;

    controle_empilement #(
        .NB_LED       (NB),
        .LARGEUR_INIT (LI),
        .PAUSE_TICKS  (PT)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .bouton (bouton),
        .leds   (leds),
        .pile   (pile),
        .aligne (aligne),
        .perdu  (perdu),
        .niveau (niveau)
    );

    always #5 clk = ~clk;

    function automatic int leds_of(int p, int wd);
        return (((1 << wd) - 1) << p) & ((1 << NB) - 1);
    endfunction

    function automatic void model_reset();
        m_state = S_PLAY; m_pos = 0; m_w = LI; m_dir = 0;
        m_pile = (1 << NB) - 1; m_aligne = 0; m_perdu = 0; m_niveau = 0; m_cnt = 0;
    endfunction

    // Game rules applied once per clock edge
    function automatic void model_step(bit en, bit bt);
        int inter;
        m_aligne = 0;
        if (m_state == S_LOST) return;
        if (m_state == S_PAUSE) begin
            if (en) begin
                m_cnt++;
                if (m_cnt >= PT) m_state = S_PLAY;
            end
            return;
        end
        if (bt) begin
            inter = leds_of(m_pos, m_w) & m_pile;
            if (inter != 0) begin
                m_pile = inter; m_w = $countones(inter); m_pos = 0; m_dir = 0;
                m_niveau = (m_niveau >= 15) ? 15 : m_niveau + 1;
                m_aligne = 1; m_cnt = 0; m_state = S_PAUSE;
            end else begin
                m_perdu = 1; m_state = S_LOST;
            end
        end else if (en && m_w < NB) begin
            // Brick bounces inside [0, NB-w]
            if (m_dir == 0) begin
                if (m_pos < NB - m_w) m_pos++;
                else begin m_dir = 1; m_pos--; end
            end else begin
                if (m_pos > 0) m_pos--;
                else begin m_dir = 0; m_pos++; end
            end
        end
    endfunction

    task automatic drive(input bit en, input bit bt);
        enable = en;
        bouton = bt;
        @(posedge clk);
        model_step(en, bt);
        #1;
        enable = 1'b0;
        bouton = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (leds !== 8'b0000_0111) begin bad++; $display("FAIL reset_leds got=%b want=%b", leds, 8'b0000_0111); end
        total++; if (pile !== 8'hFF) begin bad++; $display("FAIL reset_pile got=%b want=%b", pile, 8'hFF); end
        total++; if (aligne !== 1'b0) begin bad++; $display("FAIL reset_aligne got=%b want=0", aligne); end
        total++; if (perdu !== 1'b0) begin bad++; $display("FAIL reset_perdu got=%b want=0", perdu); end
        total++; if (niveau !== 4'd0) begin bad++; $display("FAIL reset_niveau got=%0d want=0", niveau); end
        $display("test_reset: leds=%b pile=%b", leds, pile);
    endtask

    task automatic test_bounce();
        logic [7:0] exp_tab [6] = '{8'h0E, 8'h1C, 8'h38, 8'h70, 8'hE0, 8'h70};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0);
            total++; if (leds !== exp_tab[i]) begin bad++; $display("FAIL bounce_%0d got=%b want=%b", i, leds, exp_tab[i]); end
            $display("test_bounce: tick %0d leds=%b", i, leds);
        end
    endtask

    // Placement, pause hold, narrowing and loss as one continuous game
    task automatic test_placement_and_loss();
        do_reset();
        drive(1'b0, 1'b1);
        total++; if (aligne !== 1'b1) begin bad++; $display("FAIL place1_aligne got=%b want=1", aligne); end
        total++; if (pile !== 8'h07) begin bad++; $display("FAIL place1_pile got=%b want=%b", pile, 8'h07); end
        total++; if (niveau !== 4'd1) begin bad++; $display("FAIL place1_niveau got=%0d want=1", niveau); end
        drive(1'b0, 1'b0);
        total++; if (aligne !== 1'b0) begin bad++; $display("FAIL place1_pulse got=%b want=0", aligne); end
        drive(1'b0, 1'b1);
        total++; if (niveau !== 4'd1 || aligne !== 1'b0) begin bad++; $display("FAIL pause_press niveau=%0d aligne=%b want 1/0", niveau, aligne); end
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        total++; if (leds !== 8'h07) begin bad++; $display("FAIL pause_hold got=%b want=%b", leds, 8'h07); end
        drive(1'b1, 1'b0);
        total++; if (leds !== 8'h0E) begin bad++; $display("FAIL resume_move got=%b want=%b", leds, 8'h0E); end
        drive(1'b0, 1'b1);
        total++; if (pile !== 8'h06) begin bad++; $display("FAIL place2_pile got=%b want=%b", pile, 8'h06); end
        total++; if (leds !== 8'h03) begin bad++; $display("FAIL place2_leds got=%b want=%b", leds, 8'h03); end
        total++; if (aligne !== 1'b1 || niveau !== 4'd2) begin bad++; $display("FAIL place2_flags aligne=%b niveau=%0d want 1/2", aligne, niveau); end
        $display("test_placement: pile=%b leds=%b niveau=%0d", pile, leds, niveau);
        for (int i = 0; i < PT + 3; i++) drive(1'b1, 1'b0);
        total++; if (leds !== 8'h18) begin bad++; $display("FAIL pre_loss_leds got=%b want=%b", leds, 8'h18); end
        drive(1'b0, 1'b1);
        total++; if (perdu !== 1'b1 || aligne !== 1'b0) begin bad++; $display("FAIL loss_flags perdu=%b aligne=%b want 1/0", perdu, aligne); end
        total++; if (pile !== 8'h06) begin bad++; $display("FAIL loss_pile got=%b want=%b", pile, 8'h06); end
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, i[0]);
            total++; if (leds !== 8'h18 || perdu !== 1'b1 || aligne !== 1'b0 || niveau !== 4'd2) begin
                bad++; $display("FAIL lost_frozen_%0d leds=%b perdu=%b aligne=%b niveau=%0d", i, leds, perdu, aligne, niveau);
            end
        end
        $display("test_loss: perdu=%b leds=%b", perdu, leds);
    endtask

    task automatic test_same_cycle();
        do_reset();
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        total++; if (pile !== 8'h0E) begin bad++; $display("FAIL same_cycle_pile got=%b want=%b", pile, 8'h0E); end
        total++; if (leds !== 8'h07 || aligne !== 1'b1) begin bad++; $display("FAIL same_cycle_leds leds=%b aligne=%b want %b/1", leds, aligne, 8'h07); end
        $display("test_same_cycle: pile=%b", pile);
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1);
            total++; if (aligne !== 1'b1 || niveau !== 4'((i + 1 > 15) ? 15 : i + 1)) begin
                bad++; $display("FAIL sat_%0d aligne=%b niveau=%0d want 1/%0d", i, aligne, niveau, (i + 1 > 15) ? 15 : i + 1);
            end
            drive(1'b1, 1'b0);
            drive(1'b1, 1'b0);
        end
        $display("test_saturation: niveau=%0d", niveau);
    endtask

    task automatic test_async_reset();
        // Mid-PAUSE, right after a placement
        do_reset();
        drive(1'b0, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        total++; if (leds !== 8'h07 || pile !== 8'hFF || aligne !== 1'b0 || perdu !== 1'b0 || niveau !== 4'd0) begin
            bad++; $display("FAIL async_pause leds=%b pile=%b aligne=%b perdu=%b niveau=%0d", leds, pile, aligne, perdu, niveau);
        end
        // During PERDU
        do_reset();
        drive(1'b0, 1'b1);
        for (int i = 0; i < PT + 3; i++) drive(1'b1, 1'b0);
        drive(1'b0, 1'b1);
        total++; if (perdu !== 1'b1) begin bad++; $display("FAIL async_setup_perdu got=%b want=1", perdu); end
        #2;
        reset = 1'b0;
        #1;
        total++; if (leds !== 8'h07 || pile !== 8'hFF || perdu !== 1'b0 || niveau !== 4'd0) begin
            bad++; $display("FAIL async_lost leds=%b pile=%b perdu=%b niveau=%0d", leds, pile, perdu, niveau);
        end
        $display("test_async_reset: perdu=%b niveau=%0d", perdu, niveau);
    endtask

    task automatic test_random();
        bit en, bt;
        int lost_cycles = 0;
        logic [7:0] e_leds;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            en = 1'($urandom_range(0, 1));
            bt = ($urandom_range(0, 9) == 0);
            drive(en, bt);
            e_leds = 8'(leds_of(m_pos, m_w));
            total++; if (leds !== e_leds) begin bad++; $display("FAIL rnd_leds cyc=%0d got=%b want=%b", c, leds, e_leds); end
            total++; if (pile !== 8'(m_pile)) begin bad++; $display("FAIL rnd_pile cyc=%0d got=%b want=%b", c, pile, 8'(m_pile)); end
            total++; if (aligne !== 1'(m_aligne)) begin bad++; $display("FAIL rnd_aligne cyc=%0d got=%b want=%0d", c, aligne, m_aligne); end
            total++; if (perdu !== 1'(m_perdu)) begin bad++; $display("FAIL rnd_perdu cyc=%0d got=%b want=%0d", c, perdu, m_perdu); end
            total++; if (niveau !== 4'(m_niveau)) begin bad++; $display("FAIL rnd_niveau cyc=%0d got=%0d want=%0d", c, niveau, m_niveau); end
            if (bt && m_aligne == 1) $display("rnd press cyc=%0d placed pile=%b niveau=%0d", c, pile, niveau);
            if (m_state == S_LOST) begin
                lost_cycles++;
                if (lost_cycles > 10) begin
                    $display("rnd cyc=%0d game lost at niveau=%0d, restarting", c, m_niveau);
                    lost_cycles = 0;
                    do_reset();
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_bounce();
        test_placement_and_loss();
        test_same_cycle();
        test_saturation();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
